memory_access: RTL
==================

# memory_access

Memory stage of the rv64I pipeline, directly downstream of `execute`. Takes the registered execute result (address/ALU value, store data, load/store decode, commit info), performs at most one data-memory access over a valid/ready request bus, and aligns and sign-/zero-extends load data. It drives a registered result toward writeback and stalls upstream stages while an access is in flight.

## Interface
Parameters: none. Width constants are fixed: XLEN 64, commit info 161.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `regM_i_valid` in 1: upstream holds a valid instruction.
- `regM_i_load_store_info` in 11: one-hot decode.
  - [10] lb, [9] lh, [8] lw, [7] ld, [6] lbu, [5] lhu, [4] lwu
  - [3] sb, [2] sh, [1] sw, [0] sd
  - All zero means a non-memory instruction.
- `regM_i_alu_result` in 64: effective address for memory ops, ALU result otherwise.
- `regM_i_regdata2` in 64: store data (rs2).
- `regM_i_commit_info` in 161: passed through.
- `memory_o_stall` out 1: upstream must hold its `regM_i_*` values while high.
- `memory_o_valid` out 1: registered result valid, one cycle per instruction.
- `memory_o_alu_result` out 64: registered passthrough of `regM_i_alu_result`.
- `memory_o_mem_rdata` out 64: registered load result, extended.
- `memory_o_misaligned` out 1: registered misaligned-access flag.
- `memory_o_commit_info` out 161: registered passthrough.
- `dmem_o_req_valid` out 1, `dmem_i_req_ready` in 1: request handshake.
- `dmem_o_addr` out 64: address with [2:0] forced to 0.
- `dmem_o_wen` out 1: 1 for a store.
- `dmem_o_wdata` out 64: store data, lane-shifted.
- `dmem_o_wstrb` out 8: byte strobes; zero for loads.
- `dmem_i_resp_valid` in 1, `dmem_i_resp_data` in 64: load response (full aligned doubleword).

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE with `regM_i_valid`:
  - Non-memory instruction, or misaligned memory op: complete this cycle. No bus activity, state stays IDLE.
  - Aligned memory op: latch address, wdata and wstrb into `dmem_o_*`, then go to REQ.
- REQ: `dmem_o_req_valid`=1, and all `dmem_o_*` are held stable until `dmem_i_req_ready`.
  - On handshake, a store completes and goes to IDLE.
  - On handshake, a load goes to WAIT.
- WAIT: on `dmem_i_resp_valid`, the load completes and goes to IDLE.
  - `dmem_i_resp_valid` in IDLE or REQ is ignored.
- Stall is combinational and high in these cases, low otherwise:
  - IDLE with a valid aligned memory op.
  - REQ, except a store handshake cycle.
  - WAIT without `dmem_i_resp_valid`.
- Completion: on the completing cycle's edge, load the output registers and set `memory_o_valid`=1 for exactly one cycle. The data output registers hold their value otherwise.
- Misalignment, with off = addr[2:0]:
  - h: off[0] != 0.
  - w: off[1:0] != 0.
  - d: off != 0.
  - b: never misaligned.
  - A misaligned op sets `memory_o_misaligned`=1 with `memory_o_mem_rdata`=0.
- Store lanes:
  - `dmem_o_wdata` = rs2 << (8*off).
  - wstrb: sb 0x01<<off, sh 0x03<<off, sw 0x0F<<off, sd 0xFF.
- Load extract: field = resp_data >> (8*off), truncated to the access size.
  - lb, lh, lw: sign-extended to 64 bits.
  - lbu, lhu, lwu: zero-extended.
  - ld: used as is.
- Non-memory and store completions drive `memory_o_mem_rdata`=0.
- Reset (any state, including mid-access):
  - State returns to IDLE and any outstanding request or response is abandoned.
  - Every output register clears to 0: valid, misaligned, alu_result, mem_rdata, commit_info, and all `dmem_o_*`.
  - `memory_o_stall` follows its combinational equation.

## Timing
- Non-memory or misaligned instruction: accepted in cycle N, `memory_o_valid` in N+1, no stall.
- Load with ready held high and response one cycle after handshake:
  - Accept N (stall).
  - REQ handshake N+1 (stall).
  - Response N+2 (stall low).
  - `memory_o_valid` N+3.
- Store with ready held high: accept N, handshake N+1 (stall low), `memory_o_valid` N+2.
- Each cycle `dmem_i_req_ready` stays low in REQ, or the response is absent in WAIT, adds one cycle of stall and latency.
- At most one outstanding access. No new instruction is accepted until completion, because upstream is held by stall.
- Back-to-back non-memory instructions sustain one per cycle.

## Test plan
- ld, addr 0x1000, resp_data 0x1122334455667788, ready=1 → `memory_o_mem_rdata`=0x1122334455667788 at N+3; `dmem_o_wstrb`=0.
- lb at addr 0x1005, resp_data 0x0000_8000_0000_0000 → rdata 0xFFFFFFFFFFFFFF80. Same access as lbu → 0x80.
- sw, addr 0x2004, rs2 0xDEADBEEF → `dmem_o_addr`=0x2000, wstrb 0xF0, wdata 0xDEADBEEF00000000, wen=1.
- ld with ready low 3 cycles, then response after 2 more → stall held 6 cycles, one valid pulse, addr stable throughout.
- lw at 0x3002 → misaligned=1, no `dmem_o_req_valid`, valid at N+1. Back-to-back non-memory ops with alu 5, 6 → valid two consecutive cycles, commit info preserved.
- `rst_n` low during WAIT, then a stray `dmem_i_resp_valid` → all outputs 0, FSM IDLE, stray response ignored, next instruction processed normally.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage of the rv64I pipeline. Performs at most one data-memory access per
// instruction over a valid/ready request bus, aligns and extends load data, and drives
// a registered result toward writeback while stalling upstream during an access.
module memory_access (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         regM_i_valid,
  input  logic [10:0]  regM_i_load_store_info,
  input  logic [63:0]  regM_i_alu_result,
  input  logic [63:0]  regM_i_regdata2,
  input  logic [160:0] regM_i_commit_info,
  output logic         memory_o_stall,
  output logic         memory_o_valid,
  output logic [63:0]  memory_o_alu_result,
  output logic [63:0]  memory_o_mem_rdata,
  output logic         memory_o_misaligned,
  output logic [160:0] memory_o_commit_info,
  output logic         dmem_o_req_valid,
  input  logic         dmem_i_req_ready,
  output logic [63:0]  dmem_o_addr,
  output logic         dmem_o_wen,
  output logic [63:0]  dmem_o_wdata,
  output logic [7:0]   dmem_o_wstrb,
  input  logic         dmem_i_resp_valid,
  input  logic [63:0]  dmem_i_resp_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [10:0] ls;
  logic [2:0]  off;
  logic        is_load, is_store, is_mem, misaligned;
  logic        accept, complete;
  logic [7:0]  st_strb;
  logic [63:0] st_data, ld_field, ld_ext;

  // Upstream holds regM_i_* while stalled, so live inputs stay valid for the whole access.
  assign ls       = regM_i_load_store_info;
  assign off      = regM_i_alu_result[2:0];
  assign is_load  = |ls[10:4];
  assign is_store = |ls[3:0];
  assign is_mem   = is_load | is_store;

  // Misalignment by access size; bytes can never be misaligned.
  assign misaligned = ((ls[9] | ls[5] | ls[2]) & off[0])
                    | ((ls[8] | ls[4] | ls[1]) & (|off[1:0]))
                    | ((ls[7] | ls[0]) & (|off));

  assign accept   = (state_q == IDLE) & regM_i_valid & is_mem & ~misaligned;
  assign complete = ((state_q == IDLE) & regM_i_valid & (~is_mem | misaligned))
                  | ((state_q == REQ) & dmem_i_req_ready & is_store)
                  | ((state_q == WAIT) & dmem_i_resp_valid);

  // Store lane placement within the aligned doubleword.
  assign st_data = regM_i_regdata2 << {off, 3'b000};
  always_comb begin
    st_strb = 8'h00;
    if (ls[3])      st_strb = 8'h01 << off;
    else if (ls[2]) st_strb = 8'h03 << off;
    else if (ls[1]) st_strb = 8'h0F << off;
    else if (ls[0]) st_strb = 8'hFF;
  end

  // Load extract: shift the addressed field down, then size and extend it.
  assign ld_field = dmem_i_resp_data >> {off, 3'b000};
  always_comb begin
    ld_ext = 64'd0;
    if (ls[10])     ld_ext = {{56{ld_field[7]}}, ld_field[7:0]};
    else if (ls[9]) ld_ext = {{48{ld_field[15]}}, ld_field[15:0]};
    else if (ls[8]) ld_ext = {{32{ld_field[31]}}, ld_field[31:0]};
    else if (ls[7]) ld_ext = ld_field;
    else if (ls[6]) ld_ext = {56'd0, ld_field[7:0]};
    else if (ls[5]) ld_ext = {48'd0, ld_field[15:0]};
    else if (ls[4]) ld_ext = {32'd0, ld_field[31:0]};
  end

  // Next state and combinational stall.
  always_comb begin
    state_d        = state_q;
    memory_o_stall = 1'b0;
    case (state_q)
      IDLE: begin
        memory_o_stall = accept;
        if (accept) state_d = REQ;
      end
      REQ: begin
        memory_o_stall = ~(dmem_i_req_ready & is_store);
        if (dmem_i_req_ready) state_d = is_store ? IDLE : WAIT;
      end
      WAIT: begin
        memory_o_stall = ~dmem_i_resp_valid;
        if (dmem_i_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request bus: latched on accept, held through REQ, valid dropped on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_o_req_valid <= 1'b0;
      dmem_o_addr      <= 64'd0;
      dmem_o_wen       <= 1'b0;
      dmem_o_wdata     <= 64'd0;
      dmem_o_wstrb     <= 8'd0;
    end else if (accept) begin
      dmem_o_req_valid <= 1'b1;
      dmem_o_addr      <= {regM_i_alu_result[63:3], 3'b000};
      dmem_o_wen       <= is_store;
      dmem_o_wdata     <= is_store ? st_data : 64'd0;
      dmem_o_wstrb     <= st_strb;
    end else if ((state_q == REQ) && dmem_i_req_ready) begin
      dmem_o_req_valid <= 1'b0;
    end
  end

  // Result registers: loaded only on the completing cycle, valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memory_o_valid       <= 1'b0;
      memory_o_alu_result  <= 64'd0;
      memory_o_mem_rdata   <= 64'd0;
      memory_o_misaligned  <= 1'b0;
      memory_o_commit_info <= 161'd0;
    end else begin
      memory_o_valid <= complete;
      if (complete) begin
        memory_o_alu_result  <= regM_i_alu_result;
        memory_o_mem_rdata   <= (state_q == WAIT) ? ld_ext : 64'd0;
        memory_o_misaligned  <= (state_q == IDLE) & misaligned;
        memory_o_commit_info <= regM_i_commit_info;
      end
    end
  end

endmodule
